// File: rtl/dma_burst_mover.sv
// Single-burst DMA mover: AXI4 INCR read into a local buffer, then AXI4 INCR write of the same beats.
// Optional sticky response-error flag (ERR output) when DMA_BURST_ERR_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for BURST_REQ; request fields latched here
// AR     | read address presented until ARREADY
// R      | collecting LEN+1 read beats into the buffer
// AW     | write address presented until AWREADY
// W      | streaming the buffer out, WLAST on beat LEN
// B      | waiting for the write response
// DONE   | one-cycle BURST_DONE pulse, then back to IDLE
module dma_burst_mover #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                BURST_REQ,
    input  logic [ADDR_W-1:0]   BURST_SRC,
    input  logic [ADDR_W-1:0]   BURST_DST,
    input  logic [LEN_W-1:0]    BURST_LEN,
    output logic                BUSY,
    output logic                BURST_DONE,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [LEN_W-1:0]    ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [LEN_W-1:0]    AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
`ifdef DMA_BURST_ERR_EN
    ,
    output logic                ERR
`endif
);

    localparam int DEPTH = 2 ** LEN_W;
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   rcnt_q, wcnt_q;
    logic [DATA_W-1:0]  buf_mem [DEPTH];
    logic               r_hs, w_hs, r_last, w_last, req_accept;

    assign r_hs       = RVALID & RREADY;
    assign w_hs       = WVALID & WREADY;
    assign r_last     = (rcnt_q == {1'b0, len_q});
    assign w_last     = (wcnt_q == {1'b0, len_q});
    assign req_accept = (state_q == S_IDLE) & BURST_REQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (req_accept) begin
                src_q  <= BURST_SRC;
                dst_q  <= BURST_DST;
                len_q  <= BURST_LEN;
                rcnt_q <= '0;
                wcnt_q <= '0;
            end
            if (r_hs)
                rcnt_q <= rcnt_q + CNT_W'(1);
            if (AWVALID && AWREADY)
                wcnt_q <= '0;
            if (w_hs)
                wcnt_q <= wcnt_q + CNT_W'(1);
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (r_hs)
            buf_mem[rcnt_q[LEN_W-1:0]] <= RDATA;
    end

    always_comb begin
        state_d    = state_q;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        WLAST      = 1'b0;
        BREADY     = 1'b0;
        BURST_DONE = 1'b0;
        case (state_q)
            S_IDLE: if (BURST_REQ) state_d = S_AR;
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                RREADY = 1'b1;
                // Beat count decides the end of the read; RLAST is not trusted.
                if (RVALID && r_last) state_d = S_AW;
            end
            S_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = S_W;
            end
            S_W: begin
                WVALID = 1'b1;
                WLAST  = w_last;
                if (WREADY && w_last) state_d = S_B;
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID) state_d = S_DONE;
            end
            S_DONE: begin
                BURST_DONE = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fixed AXI fields are qualified by their VALID so every output reads 0 while idle.
    assign BUSY    = (state_q != S_IDLE);
    assign ARADDR  = src_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = ARVALID ? 3'b010 : 3'b000;
    assign ARBURST = ARVALID ? 2'b01 : 2'b00;
    assign AWADDR  = dst_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = AWVALID ? 3'b010 : 3'b000;
    assign AWBURST = AWVALID ? 2'b01 : 2'b00;
    assign WDATA   = WVALID ? buf_mem[wcnt_q[LEN_W-1:0]] : '0;
    assign WSTRB   = {(DATA_W/8){WVALID}};

`ifdef DMA_BURST_ERR_EN
    logic err_q;
    logic unused_resp;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (req_accept)
            err_q <= 1'b0;
        else if ((r_hs && RRESP != 2'b00) || (BVALID && BREADY && BRESP != 2'b00))
            err_q <= 1'b1;
    end

    assign ERR         = err_q;
    assign unused_resp = RLAST;
`else
    logic unused_resp;
    assign unused_resp = ^{RRESP, BRESP, RLAST};
`endif

endmodule

// File: doc/dma_burst_mover.md
Name: dma_burst_mover

Overview:
- Datapath stage directly downstream of the DMA descriptor/burst register block.
- Takes one burst request (source address, destination address, length) and performs one AXI4 INCR read burst from the source into a local 16-entry buffer.
- Then performs one AXI4 INCR write burst of the same data to the destination.
- Pulses BURST_DONE back to the register block when the write response has been received.

Parameters:
- ADDR_W, 32, address width (matches `AXI_ADDR_BITS)
- DATA_W, 32, data width (matches `AXI_DATA_BITS); WSTRB width is DATA_W/8
- LEN_W, 4, burst length field width (matches `AXI_LEN_BITS); buffer depth is 2**LEN_W

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- BURST_REQ  in  1  one-cycle request strobe; sampled only in IDLE
- BURST_SRC  in  ADDR_W  source start address
- BURST_DST  in  ADDR_W  destination start address
- BURST_LEN  in  LEN_W  beats minus one (0..15)
- BUSY  out  1  high in every state except IDLE
- BURST_DONE  out  1  one-cycle completion pulse
- ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ADDR_W/LEN_W/3/2/1  AXI read address
- ARREADY  in  1  read address ready
- RDATA/RRESP/RLAST/RVALID  in  DATA_W/2/1/1  read data
- RREADY  out  1  read data ready
- AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ADDR_W/LEN_W/3/2/1  write address
- AWREADY  in  1  write address ready
- WDATA/WSTRB/WLAST/WVALID  out  DATA_W/DATA_W/8/1/1  write data
- WREADY  in  1  write data ready
- BRESP/BVALID  in  2/1  write response
- BREADY  out  1  write response ready

Behaviour:
- Reset: all outputs 0; state IDLE; beat counters 0; buffer contents don't-care.
  - Reset applied mid-burst returns the block to IDLE on that edge and drops every VALID/READY.
  - No BURST_DONE is issued for the abandoned burst.
- Fixed fields:
  - ARSIZE=AWSIZE=3'b010.
  - ARBURST=AWBURST=2'b01 (INCR).
  - WSTRB all ones.
- Latched at request: on BURST_REQ in IDLE, latch SRC/DST/LEN into internal registers; go to AR next cycle.
  - AR*/AW* outputs drive the latched values, never the live inputs.
- Busy requests: BURST_REQ outside IDLE is ignored; there is no queueing.
- AR state: ARVALID=1 and held stable until ARREADY; on handshake go to R.
- R state: RREADY=1.
  - Each RVALID&RREADY writes RDATA into buf[rcnt] and increments rcnt.
  - The beat with rcnt==LEN is last; go to AW after it regardless of RLAST.
  - An RLAST seen earlier is ignored; the beat count is authoritative.
- AW state: AWVALID=1 until AWREADY; then go to W with wcnt=0.
- W state: WVALID=1, WDATA=buf[wcnt], WLAST=(wcnt==LEN).
  - WDATA/WLAST stay stable while WREADY=0.
  - wcnt increments on each handshake; after the WLAST handshake go to B.
- B state: BREADY=1; on BVALID go to DONE.
- DONE state: BURST_DONE=1 for exactly one cycle; BUSY=1; next state IDLE.
  - A new BURST_REQ can be accepted on the cycle after DONE, at the earliest.
- Minimum latency for LEN=0 with all ready signals tied high is 6 cycles from the REQ edge to BURST_DONE: AR, R, AW, W, B, DONE.
- Response codes: RRESP/BRESP are ignored in the base build.
- Arithmetic: counters are LEN_W+1 bits, so LEN=15 gives 16 beats with no wrap ambiguity. No 4KB boundary check; the upstream block guarantees it.

Optional Feature:
- Macro: DMA_BURST_ERR_EN
- When defined:
  - Adds output ERR (1 bit), reset 0.
  - ERR is set sticky on any RRESP!=0 read beat or BRESP!=0 response.
  - ERR is cleared only by rst, or by BURST_REQ accepted in IDLE.
  - The transfer still completes and BURST_DONE still pulses.
- When undefined: no ERR port; responses are ignored.

Test Plan:
- 16-beat burst, all readys high: REQ with SRC=0x1000, DST=0x2000, LEN=15 and RDATA=i.
  - Required: ARADDR=0x1000, ARLEN=15, AWADDR=0x2000.
  - Required: 16 W beats carry 0..15, with WLAST on beat 15 only.
  - Required: one BURST_DONE pulse.
- 1-beat burst: LEN=0, RDATA=0xDEADBEEF.
  - Required: a single W beat 0xDEADBEEF with WLAST=1.
  - Required: BURST_DONE exactly 6 cycles after the REQ edge.
- Backpressure: ARREADY delayed 3 cycles, RVALID gapped every other cycle, WREADY toggled.
  - Required: ARADDR/WDATA stay stable while stalled.
  - Required: the write data order matches the read order.
- REQ while busy: second BURST_REQ (SRC=0x3000) during the W state.
  - Required: it is ignored; no second AR appears.
  - Required: BUSY stays 1 until DONE, then drops to 0.
- Reset mid-write: rst for 1 cycle after 5 of 8 W beats.
  - Required: all VALIDs drop to 0, BUSY=0, no BURST_DONE.
  - Required: a subsequent REQ completes normally.
- With DMA_BURST_ERR_EN: RRESP=2'b10 on beat 3.
  - Required: ERR=1 from that beat onward; BURST_DONE still pulses.
  - Required: ERR returns to 0 when the next BURST_REQ is accepted.
